// File: rtl/store_narrow_if.sv
// Handshake bundle for the store narrowing unit: request side (in_*) and memory side (out_*).
interface store_narrow_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_addr;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        out_misalign;

  // slave: the narrowing unit; master: the environment driving requests and accepting results
  modport slave (
    input  in_valid, in_data, in_addr, in_size, out_ready,
    output in_ready, out_valid, out_wdata, out_be, out_misalign
  );
  modport master (
    output in_valid, in_data, in_addr, in_size, out_ready,
    input  in_ready, out_valid, out_wdata, out_be, out_misalign
  );
endinterface

// File: rtl/store_narrow.sv
// Store-path narrowing: replicates store data across byte lanes, builds byte enables and a
// misalignment flag, and buffers results in a DEPTH-entry FIFO with valid/ready on both sides.
module store_narrow #(
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  store_narrow_if.slave bus,
  output logic [15:0]   stores_issued
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;

  logic [PtrW:0] count_q, count_d;
  ptr_t          wr_ptr_q, rd_ptr_q;
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic          mis_q   [DEPTH];
  logic [15:0]   issued_q;

  logic [31:0] nar_wdata;
  logic [3:0]  nar_be;
  logic        nar_mis;
  logic        head_valid, push, pop;

  always_comb begin
    nar_wdata = bus.in_data;
    nar_be    = 4'b0000;
    nar_mis   = 1'b0;
    unique case (bus.in_size)
      2'b00: begin
        nar_wdata = {4{bus.in_data[7:0]}};
        nar_be    = 4'b0001 << bus.in_addr;
      end
      2'b01: begin
        nar_wdata = {2{bus.in_data[15:0]}};
        if (bus.in_addr[0]) begin
          nar_mis = 1'b1;
        end else begin
          nar_be = bus.in_addr[1] ? 4'b1100 : 4'b0011;
        end
      end
      2'b10: begin
        if (bus.in_addr == 2'b00) begin
          nar_be = 4'b1111;
        end else begin
          nar_mis = 1'b1;
        end
      end
      2'b11: begin
        nar_mis = 1'b1;
      end
    endcase
  end

  // No ready bypass: a full FIFO refuses pushes even while it is popping.
  always_comb begin
    head_valid       = (count_q != '0);
    bus.in_ready     = !rst && (count_q != FullCount);
    bus.out_valid    = head_valid;
    bus.out_wdata    = head_valid ? wdata_q[rd_ptr_q] : 32'h0;
    bus.out_be       = head_valid ? be_q[rd_ptr_q] : 4'b0000;
    bus.out_misalign = head_valid ? mis_q[rd_ptr_q] : 1'b0;
    stores_issued    = issued_q;
  end

  always_comb begin
    push    = bus.in_valid && bus.in_ready;
    pop     = head_valid && bus.out_ready;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      issued_q <= 16'h0;
      for (int i = 0; i < DEPTH; i++) begin
        wdata_q[i] <= 32'h0;
        be_q[i]    <= 4'b0000;
        mis_q[i]   <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        wdata_q[wr_ptr_q] <= nar_wdata;
        be_q[wr_ptr_q]    <= nar_be;
        mis_q[wr_ptr_q]   <= nar_mis;
        wr_ptr_q          <= wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
        issued_q <= issued_q + 16'd1;
      end
    end
  end

endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
- Store-path data narrowing unit in the Memory stage; the inverse of the Decode-stage sign extenders.
- Takes a 32-bit register value, a store size and the low address bits, and produces lane-replicated write data, byte enables and a misalignment flag for the data memory.
- Results are buffered in a small FIFO with valid/ready handshakes on both sides, so memory stalls do not drop stores.

Parameters:
DEPTH, 2, number of buffered store entries; power of two, >= 2.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream store request valid
in_ready  output  1  unit can accept a request this cycle
in_data  input  32  register value to store (rs2)
in_addr  input  2  byte address bits [1:0]
in_size  input  2  00 byte, 01 half, 10 word, 11 illegal
out_valid  output  1  head entry valid
out_ready  input  1  memory accepts head entry
out_wdata  output  32  lane-replicated write data
out_be  output  4  byte enables, bit i = byte lane i
out_misalign  output  1  request misaligned or illegal size
stores_issued  output  16  count of completed output handshakes, wraps at 2^16

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- On rst assertion, immediately and for as long as rst is high:
  - count and pointers = 0, all entries invalid, stores_issued = 0.
  - out_valid = 0, out_wdata = 0, out_be = 0, out_misalign = 0, in_ready = 0.
  - Reset mid-operation discards all buffered entries; no partial output.
- After reset deasserts: in_ready = (count != DEPTH).
- Push: occurs when in_valid && in_ready at a rising edge.
  - The narrowed result is computed combinationally from in_* and written to the tail.
  - Latency is 1 cycle: a push into an empty FIFO at edge N gives out_valid = 1 during cycle N+1.
- Pop: occurs when out_valid && out_ready at a rising edge; stores_issued increments by 1.
- Full FIFO: in_ready = 0 even if a pop occurs in the same cycle; there is no combinational ready bypass.
- Simultaneous push and pop with count between 1 and DEPTH-1: count is unchanged and both pointers advance.
- Empty FIFO: out_valid = 0 and out_wdata, out_be, out_misalign read 0.
- Pointers wrap modulo DEPTH.
- Narrowing rules:
  - byte: wdata = {4{in_data[7:0]}}, be = 4'b0001 << in_addr, misalign = 0.
  - half: wdata = {2{in_data[15:0]}}.
    - in_addr[0] = 1: misalign = 1, be = 0000.
    - Otherwise be = 0011 when in_addr[1] = 0 and 1100 when in_addr[1] = 1.
  - word: wdata = in_data.
    - in_addr = 00: be = 1111, misalign = 0.
    - Any other in_addr: be = 0000, misalign = 1.
  - size 11: wdata = in_data, be = 0000, misalign = 1.
- Misaligned entries are still queued and handshaken normally; the trap is raised downstream.
- Outputs hold stable while out_valid && !out_ready.
- stores_issued counts all pops, including misaligned ones, and wraps from FFFF to 0000.

Test Plan:
- Byte store: in_data=0x12345678, size=00, addr=2 -> next cycle out_valid=1, out_wdata=0x78787878, out_be=0100, out_misalign=0.
- Half store: in_data=0xCAFEBEEF, size=01, addr=2 -> out_wdata=0xBEEFBEEF, out_be=1100. Same with addr=1 -> out_be=0000, out_misalign=1.
- Word store: in_data=0xDEADBEEF, size=10, addr=0 -> out_be=1111, out_wdata=0xDEADBEEF. Same with addr=3 -> out_misalign=1. Illegal: size=11 -> out_be=0000, out_misalign=1.
- Backpressure: out_ready=0, push three stores -> in_ready falls after 2 pushes and the 3rd is held. Raise out_ready -> entries emerge in order with unchanged data, and stores_issued reaches 3 after the 3rd pop.
- Full with simultaneous pop: count=2, in_valid=1, out_ready=1 -> pop happens, push blocked that cycle (in_ready=0), push occurs the next cycle.
- Async reset mid-stream: 2 entries queued, pulse rst between clock edges -> out_valid, out_be and stores_issued drop to 0 immediately with no clock edge; the first post-reset push appears 1 cycle later.
